bcd_hex_display: RTL and testbench

//  Downstream display stage for the processor core: takes a 16-bit unsigned result word over a

---
 rtl/bcd_hex_display.sv | 121 ++++++++++++
 tb/tb_bcd_hex_display.sv | 130 +++++++++++++
 2 files changed

// File: rtl/bcd_hex_display.sv
// bcd_hex_display: binary word to decimal via sequential double-dabble, driven onto active-low 7-seg HEX0..HEX5; define BCD_LZB_EN for leading-zero blanking
module bcd_hex_display #(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        done,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);
    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [19:0]      bcd_q, bcd_d, bcd_adj;
    logic [19:0]      dig_q, dig_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [4:0]       show;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    // add 3 to every BCD nibble that is 5 or more, ahead of the shift
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 5; i++)
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end

    // next-state: accept in IDLE, WIDTH shift steps, then load the display digits
    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (in_valid) begin
                bin_d   = in_data[WIDTH-1:0];
                bcd_d   = '0;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 5'd1;
                if (cnt_q == 5'(WIDTH - 1))
                    state_d = LOAD;
            end
            LOAD: begin
                dig_d   = bcd_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            dig_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
            done_q  <= done_d;
        end
    end

    // which digits are lit: a digit blanks only when it and all higher digits are zero
    always_comb begin
`ifdef BCD_LZB_EN
        show[4] = |dig_q[19:16];
        show[3] = |dig_q[19:12];
        show[2] = |dig_q[19:8];
        show[1] = |dig_q[19:4];
        show[0] = 1'b1;
`else
        show = '1;
`endif
    end

    assign in_ready = state_q == IDLE;
    assign done     = done_q;
    assign HEX0     = show[0] ? seg7(dig_q[3:0])   : 7'h7F;
    assign HEX1     = show[1] ? seg7(dig_q[7:4])   : 7'h7F;
    assign HEX2     = show[2] ? seg7(dig_q[11:8])  : 7'h7F;
    assign HEX3     = show[3] ? seg7(dig_q[15:12]) : 7'h7F;
    assign HEX4     = show[4] ? seg7(dig_q[19:16]) : 7'h7F;
    assign HEX5     = 7'h7F;
endmodule

// File: tb/tb_bcd_hex_display.sv
// tb_bcd_hex_display: random and directed conversions checked against a decimal arithmetic model
module tb_bcd_hex_display;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready, done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [34:0] disp;
    int          n_cmp = 0;
    int          n_err = 0;
    int          shown = 0;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    bcd_hex_display dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .done(done), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
    );

    assign disp = {HEX4, HEX3, HEX2, HEX1, HEX0};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] disp_of(input int v);
        logic [34:0] r;
        logic [6:0]  s;
        int          p;
        p = 1;
        for (int k = 0; k < 5; k++) begin
            s = SEG[(v / p) % 10];
`ifdef BCD_LZB_EN
            if (k > 0 && v < p) s = 7'h7F;
`endif
            r[7*k +: 7] = s;
            p *= 10;
        end
        return r;
    endfunction

    task automatic convert(input int v);
        @(negedge clk);
        check("ready_idle", in_ready, 1);
        in_data  = 16'(v);
        in_valid = 1'b1;
        for (int i = 0; i <= 17; i++) begin
            @(negedge clk);
            if (i == 17) shown = v;
            check("done", done, i == 17);
            check("ready", in_ready, i == 17);
            check("disp", disp, disp_of(shown));
            in_valid = i < 16 ? 1'($urandom) : 1'b0;
            in_data  = 16'($urandom);
        end
        @(negedge clk);
        check("done_clr", done, 0);
        check("disp_hold", disp, disp_of(shown));
    endtask

    initial begin
        int highs;
        #2 rst = 1'b1;
        #10;
        check("rst_ready", in_ready, 1);
        check("rst_done", done, 0);
        check("rst_disp", disp, disp_of(0));
        check("rst_hex5", HEX5, 7'h7F);
        @(negedge clk);
        rst = 1'b0;
        convert(1234);
        convert(65535);
        check("ffff_digits", disp[34:0], {7'b0000010, 7'b0010010, 7'b0010010, 7'b0110000, 7'b0010010});
        convert(0);
        foreach (SEG[d]) convert(d);
        convert(10);
        convert(100);
        convert(9999);
        convert(10000);
        // back-to-back with data change while busy
        @(negedge clk);
        in_data  = 16'd1234;
        in_valid = 1'b1;
        for (int i = 0; i <= 35; i++) begin
            @(negedge clk);
            if (i == 17) shown = 1234;
            if (i == 35) shown = 42;
            check("b2b_done", done, i == 17 || i == 35);
            check("b2b_ready", in_ready, i == 17 || i == 35);
            check("b2b_disp", disp, disp_of(shown));
            if (i == 5) in_data = 16'd42;
            if (i == 35) in_valid = 1'b0;
        end
        // reset in the middle of a conversion
        @(negedge clk);
        in_data  = 16'd9999;
        in_valid = 1'b1;
        for (int i = 0; i <= 8; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        shown = 0;
        check("abort_ready", in_ready, 1);
        check("abort_done", done, 0);
        check("abort_disp", disp, disp_of(0));
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        highs    = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            highs += int'(done);
        end
        check("abort_no_done", highs, 0);
        convert(9999);
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert($urandom_range(0, 65535));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
